// File: rtl/pc_sequencer_if.sv
// Decode/config side to PC sequencer bundle: control strobes, table writes, PC/status back.
// Latency: n/a (wiring only).
// Backpressure: none; stall is the only hold mechanism and it travels inside this bundle.
//
// Ports (master = decode/config driver, slave = pc_sequencer):
//   start, stall, branch, idx, halt   decode controls into the sequencer
//   cfg_we, cfg_idx, cfg_data         branch-target table write port
//   pc, running, done, cycles         sequencer outputs
interface pc_sequencer_if #(
  parameter int D  = 8,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          branch;
  logic [2:0]    idx;
  logic          halt;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [D-1:0]  cfg_data;
  logic [D-1:0]  pc;
  logic          running;
  logic          done;
  logic [CW-1:0] cycles;

  modport master (
    output start, stall, branch, idx, halt, cfg_we, cfg_idx, cfg_data,
    input  pc, running, done, cycles
  );

  modport slave (
    input  start, stall, branch, idx, halt, cfg_we, cfg_idx, cfg_data,
    output pc, running, done, cycles
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: owns PC, IDLE/RUN/DONE state, 8-entry absolute branch-target table, run-cycle counter.
// Latency: decode inputs in cycle N set pc in cycle N+1; table read is combinational.
// Backpressure: stall holds pc (cycle counter still advances); no other flow control.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high; returns state, pc, cycles and table to defaults
//   bus    pc_sequencer_if slave: decode controls, table write port, pc/running/done/cycles
module pc_sequencer #(
  parameter int D  = 8,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [D-1:0]  pc_q, pc_nxt;
  logic [CW-1:0] cyc_q, cyc_nxt, cyc_sat;
  logic [D-1:0]  tbl [8];

  // Counter saturates at all-ones rather than wrapping.
  assign cyc_sat = (cyc_q == {CW{1'b1}}) ? cyc_q : cyc_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
      cyc_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      cyc_q <= cyc_nxt;
    end
  end

  // Table writes land on the edge, so a same-cycle branch still reads the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl[0] <= D'(4);
      tbl[1] <= D'(8);
      for (int i = 2; i < 8; i++) tbl[i] <= '0;
    end else if (bus.cfg_we) begin
      tbl[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cyc_nxt   = cyc_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cyc_nxt   = '0;
        end
      end
      RUN: begin
        if (bus.start) begin
          pc_nxt  = '0;
          cyc_nxt = '0;
        end else if (bus.halt) begin
          // The halting edge freezes pc and is not counted as a run cycle.
          state_nxt = DONE;
        end else begin
          cyc_nxt = cyc_sat;
          if (bus.stall) begin
            pc_nxt = pc_q;
          end else if (bus.branch) begin
            pc_nxt = tbl[bus.idx];
          end else begin
            pc_nxt = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cyc_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        cyc_nxt   = '0;
      end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.cycles  = cyc_q;
  assign bus.running = (state == RUN);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a CW=16 instance for function, a CW=4 instance for saturation.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: n/a.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.D(8), .CW(16)) b  ();
  pc_sequencer_if #(.D(8), .CW(4))  b4 ();

  pc_sequencer #(.D(8), .CW(16)) u0 (.clk(clk), .reset(reset), .bus(b.slave));
  pc_sequencer #(.D(8), .CW(4))  u1 (.clk(clk), .reset(reset), .bus(b4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    b.start = 0; b.stall = 0; b.branch = 0; b.idx = 0; b.halt = 0;
    b.cfg_we = 0; b.cfg_idx = 0; b.cfg_data = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    b4.start = 0; b4.stall = 0; b4.branch = 0; b4.idx = 0; b4.halt = 0;
    b4.cfg_we = 0; b4.cfg_idx = 0; b4.cfg_data = 0;
    #3;
    chk("rst_pc",      32'(b.pc),      32'd0);
    chk("rst_running", 32'(b.running), 32'd0);
    chk("rst_done",    32'(b.done),    32'd0);
    chk("rst_cycles",  32'(b.cycles),  32'd0);
    #9 reset = 1'b0;

    // IDLE ignores decode inputs other than start.
    b.branch = 1; b.idx = 1; b.halt = 1; b.stall = 1;
    tick();
    chk("idle_pc",      32'(b.pc),      32'd0);
    chk("idle_running", 32'(b.running), 32'd0);
    clr();

    // Start, then free-run five cycles.
    b.start = 1;
    tick();
    b.start = 0;
    chk("start_pc",      32'(b.pc),      32'd0);
    chk("start_running", 32'(b.running), 32'd1);
    chk("start_cycles",  32'(b.cycles),  32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(b.pc), 32'(i));
    end
    chk("seq_cycles",  32'(b.cycles),  32'd5);
    chk("seq_running", 32'(b.running), 32'd1);

    // Restart mid-run and reach pc=2.
    b.start = 1;
    tick();
    b.start = 0;
    chk("restart_pc",     32'(b.pc),     32'd0);
    chk("restart_cycles", 32'(b.cycles), 32'd0);
    tick(); tick();
    chk("pc2", 32'(b.pc), 32'd2);

    // Default table entries.
    b.branch = 1; b.idx = 1; tick();
    chk("br_idx1", 32'(b.pc), 32'h08);
    b.idx = 0; tick();
    chk("br_idx0", 32'(b.pc), 32'h04);
    b.idx = 5; tick();
    chk("br_idx5", 32'(b.pc), 32'h00);
    chk("br_cycles", 32'(b.cycles), 32'd5);
    b.branch = 0;

    // Same-cycle write and branch reads the old entry.
    tick();
    chk("pc1", 32'(b.pc), 32'd1);
    b.cfg_we = 1; b.cfg_idx = 3; b.cfg_data = 8'h20; b.branch = 1; b.idx = 3;
    tick();
    chk("wr_br_old", 32'(b.pc), 32'h00);
    b.cfg_we = 0;
    tick();
    chk("wr_br_new", 32'(b.pc), 32'h20);

    // Load entry2=6 while incrementing, then branch to it.
    b.branch = 0; b.cfg_we = 1; b.cfg_idx = 2; b.cfg_data = 8'h06;
    tick();
    chk("inc_21", 32'(b.pc), 32'h21);
    b.cfg_we = 0; b.branch = 1; b.idx = 2;
    tick();
    chk("br_pc6",  32'(b.pc),     32'h06);
    chk("cyc_10",  32'(b.cycles), 32'd10);

    // Stall outranks branch; stalled cycle still counts.
    b.stall = 1; b.idx = 1;
    tick();
    chk("stall_pc",     32'(b.pc),     32'h06);
    chk("stall_cycles", 32'(b.cycles), 32'd11);

    // Halt with stall: DONE, pc and cycles frozen.
    b.halt = 1;
    tick();
    chk("halt_done",    32'(b.done),    32'd1);
    chk("halt_running", 32'(b.running), 32'd0);
    chk("halt_pc",      32'(b.pc),      32'h06);
    chk("halt_cycles",  32'(b.cycles),  32'd11);
    b.halt = 0; b.stall = 0; b.branch = 1; b.idx = 1;
    tick(); tick();
    chk("done_br_pc",     32'(b.pc),     32'h06);
    chk("done_br_done",   32'(b.done),   32'd1);
    chk("done_br_cycles", 32'(b.cycles), 32'd11);

    // Start out of DONE.
    clr();
    b.start = 1;
    tick();
    b.start = 0;
    chk("redo_pc",      32'(b.pc),      32'd0);
    chk("redo_done",    32'(b.done),    32'd0);
    chk("redo_running", 32'(b.running), 32'd1);
    chk("redo_cycles",  32'(b.cycles),  32'd0);

    // Table survives start: entry3 still 0x20.
    b.branch = 1; b.idx = 3;
    tick();
    chk("tbl_keep", 32'(b.pc), 32'h20);

    // Wrap 0xFF -> 0x00.
    b.idx = 4; b.cfg_we = 1; b.cfg_idx = 4; b.cfg_data = 8'hFE; b.branch = 0;
    tick();
    b.cfg_we = 0; b.branch = 1;
    tick();
    chk("wrap_fe", 32'(b.pc), 32'hFE);
    b.branch = 0;
    tick();
    chk("wrap_ff", 32'(b.pc), 32'hFF);
    tick();
    chk("wrap_00", 32'(b.pc), 32'h00);

    // CW=4 instance: counter saturates at 15.
    b4.start = 1;
    tick();
    b4.start = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cycles", 32'(b4.cycles), 32'd15);
    chk("sat_pc",     32'(b4.pc),     32'd20);

    // Async reset between edges.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_pc",      32'(b.pc),      32'd0);
    chk("arst_running", 32'(b.running), 32'd0);
    chk("arst_done",    32'(b.done),    32'd0);
    chk("arst_cycles",  32'(b.cycles),  32'd0);
    #2 reset = 1'b0;
    tick();
    chk("arst_idle_pc",  32'(b.pc),      32'd0);
    chk("arst_idle_run", 32'(b.running), 32'd0);
    b.start = 1;
    tick();
    b.start = 0;
    chk("arst_start_pc", 32'(b.pc),      32'd0);
    chk("arst_start_rn", 32'(b.running), 32'd1);
    tick();
    chk("arst_inc_pc", 32'(b.pc), 32'd1);
    b.branch = 1; b.idx = 3;
    tick();
    chk("arst_tbl3", 32'(b.pc), 32'h00);
    b.idx = 1;
    tick();
    chk("arst_tbl1", 32'(b.pc), 32'h08);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
